wide_add_sequencer: RTL and testbench

//   Multi-cycle wide add/subtract sequencer for the modexp datapath.

---
 rtl/wide_add_sequencer.sv | 144 ++++++++++++++
 tb/tb_wide_add_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : wide_add_sequencer
// Description : Multi-cycle wide add/subtract sequencer. Splits two
//               WORD_W*NUM_WORDS operands into WORD_W limbs and feeds them
//               LSB-first to an external combinational WORD_W-bit adder, one
//               limb per cycle. The carry is chained between limbs in a
//               register and the wide sum is reassembled limb by limb.
//               Subtract mode computes A + ~B + 1 (cout = 1 means no borrow).
// Ports       : clk, rst            clock, synchronous active-high reset
//               start, sub, cin     request, mode select, add-mode carry-in
//               a_in, b_in          wide operands, sampled on accept
//               busy, done          state != IDLE, one-cycle result pulse
//               sum_out, cout       wide result and final carry
//               add_a/add_b/add_cin drive the external adder inputs
//               add_s/add_cout      captured from the external adder outputs
// Revision    : 1.0  initial release
// ============================================================================
module wide_add_sequencer #(
    parameter int WORD_W    = 64,
    parameter int NUM_WORDS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        sub,
    input  logic                        cin,
    input  logic [WORD_W*NUM_WORDS-1:0] a_in,
    input  logic [WORD_W*NUM_WORDS-1:0] b_in,
    output logic                        busy,
    output logic                        done,
    output logic [WORD_W*NUM_WORDS-1:0] sum_out,
    output logic                        cout,
    output logic [WORD_W-1:0]           add_a,
    output logic [WORD_W-1:0]           add_b,
    output logic                        add_cin,
    input  logic [WORD_W-1:0]           add_s,
    input  logic                        add_cout
);

    localparam int               c_TOT_W    = WORD_W * NUM_WORDS;
    localparam logic [1:0]       c_ST_IDLE  = 2'd0;
    localparam logic [1:0]       c_ST_RUN   = 2'd1;
    localparam logic [1:0]       c_ST_DONE  = 2'd2;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [1:0]         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx,   w_idx_nxt;
    logic               r_carry, w_carry_nxt;
    logic [c_TOT_W-1:0] r_a,     w_a_nxt;
    logic [c_TOT_W-1:0] r_b,     w_b_nxt;
    logic [c_TOT_W-1:0] r_sum,   w_sum_nxt;
    logic               r_cout,  w_cout_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_carry <= w_carry_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_sum   <= w_sum_nxt;
            r_cout  <= w_cout_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_carry_nxt = r_carry;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_sum_nxt   = r_sum;
        w_cout_nxt  = r_cout;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B once here and seed
                    // the carry chain with 1.
                    w_a_nxt     = a_in;
                    w_b_nxt     = sub ? ~b_in : b_in;
                    w_carry_nxt = sub ? 1'b1 : cin;
                    w_idx_nxt   = '0;
                    w_sum_nxt   = '0;
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    if (r_idx == IDX_W'(i)) begin
                        w_sum_nxt[i*WORD_W +: WORD_W] = add_s;
                    end
                end
                w_carry_nxt = add_cout;
                w_idx_nxt   = r_idx + 1'b1;
                if (r_idx == c_LAST_IDX) begin
                    w_cout_nxt  = add_cout;
                    w_idx_nxt   = '0;
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Adder drive: current limb during RUN, zero otherwise.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (r_state == c_ST_RUN) begin
            add_cin = r_carry;
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    add_a = r_a[i*WORD_W +: WORD_W];
                    add_b = r_b[i*WORD_W +: WORD_W];
                end
            end
        end
    end

    assign busy    = (r_state != c_ST_IDLE);
    assign done    = (r_state == c_ST_DONE);
    assign sum_out = r_sum;
    assign cout    = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wide_add_sequencer
// Description : Self-checking bench for wide_add_sequencer with a behavioural
//               64-bit adder on the add_* ports. Expected {cout, sum} values
//               are queued at issue time; a monitor pops on every done pulse.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wide_add_sequencer;

    localparam int W  = 64;
    localparam int N  = 4;
    localparam int TW = W * N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          sub = 1'b0;
    logic          cin = 1'b0;
    logic [TW-1:0] a_in = '0;
    logic [TW-1:0] b_in = '0;
    logic          busy, done, cout;
    logic [TW-1:0] sum_out;
    logic [W-1:0]  add_a, add_b, add_s;
    logic          add_cin, add_cout;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [TW:0] exp_q[$];

    wide_add_sequencer #(.WORD_W(W), .NUM_WORDS(N), .IDX_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .sum_out(sum_out), .cout(cout), .add_a(add_a), .add_b(add_b),
        .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout)
    );

    // Behavioural stand-in for the external combinational adder
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                logic [TW:0] e;
                e = exp_q.pop_front();
                chk("sum_out", sum_out, e[TW-1:0]);
                chk("cout", {{(TW-1){1'b0}}, cout}, {{(TW-1){1'b0}}, e[TW]});
            end
        end
    end

    function automatic logic [TW:0] golden(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                           input logic s, input logic c);
        if (s) return {1'b0, a} + {1'b0, ~b} + 1;
        return {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, c};
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of cycle 1.
    task automatic issue(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic s,
                         input logic c, input logic [TW:0] exp, input bit push);
        start = 1'b1; a_in = a; b_in = b; sub = s; cin = c;
        if (push) exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0; a_in = ~a; b_in = ~b; sub = ~s; cin = ~c;
    endtask

    // From the negedge of cycle 1: checks busy each cycle, done in cycle N+1,
    // idle in cycle N+2.
    task automatic wait_done_timed();
        int cyc = 1;
        bit seen = 0;
        while (!seen && cyc < 20) begin
            chk("busy_running", {{(TW-1){1'b0}}, busy}, 1);
            if (done) begin
                seen = 1;
                chk("done_cycle", TW'(cyc), TW'(N + 1));
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=0 required=1");
        end
        @(negedge clk);
        chk("busy_after", {{(TW-1){1'b0}}, busy}, 0);
        chk("done_after", {{(TW-1){1'b0}}, done}, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL idle_timeout actual=1 required=0");
        end
    endtask

    initial begin
        logic [TW-1:0] ra, rb;
        logic          rs, rc;
        int            dc0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // Reset state
        chk("rst_busy", {{(TW-1){1'b0}}, busy}, 0);
        chk("rst_done", {{(TW-1){1'b0}}, done}, 0);
        chk("rst_sum", sum_out, 0);
        chk("rst_cout", {{(TW-1){1'b0}}, cout}, 0);
        chk("rst_add_a", {{(TW-W){1'b0}}, add_a}, 0);
        chk("rst_add_b", {{(TW-W){1'b0}}, add_b}, 0);
        chk("rst_add_cin", {{(TW-1){1'b0}}, add_cin}, 0);

        // 1: carry ripples from limb 0 into limb 1
        issue({192'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 256'h1, 1'b0, 1'b0,
              {1'b0, 64'h0, 64'h0, 64'h1, 64'h0}, 1);
        wait_done_timed();

        // 2: carry ripples through every limb and out
        issue({TW{1'b1}}, 256'h0, 1'b0, 1'b1, {1'b1, 256'h0}, 1);
        wait_done_timed();

        // 3: subtraction, no borrow and borrow
        issue(256'd5, 256'd3, 1'b1, 1'b0, {1'b1, 256'd2}, 1);
        wait_done_timed();
        issue(256'd3, 256'd5, 1'b1, 1'b0,
              {1'b0, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE}, 1);
        wait_done_timed();
        // Adder ports idle again
        chk("idle_add_a", {{(TW-W){1'b0}}, add_a}, 0);
        chk("idle_add_cin", {{(TW-1){1'b0}}, add_cin}, 0);

        // 4: start during RUN is ignored
        dc0 = done_cnt;
        issue(256'd100, 256'd23, 1'b0, 1'b0, {1'b0, 256'd123}, 1);
        @(negedge clk);                       // cycle 2
        start = 1'b1; a_in = 256'd999; b_in = 256'd1; sub = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("single_done", TW'(done_cnt - dc0), 1);

        // 5: reset during RUN aborts the operation
        issue(256'd1234, 256'd4321, 1'b0, 1'b0, '0, 0);
        @(negedge clk);                       // cycle 2
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {{(TW-1){1'b0}}, busy}, 0);
        chk("abort_done", {{(TW-1){1'b0}}, done}, 0);
        chk("abort_sum", sum_out, 0);
        issue(256'd7, 256'd8, 1'b0, 1'b0, {1'b0, 256'd15}, 1);
        wait_done_timed();

        // 6: random back-to-back operations
        for (int k = 0; k < 1000; k++) begin
            for (int j = 0; j < TW / 32; j++) begin
                ra[j*32 +: 32] = $urandom;
                rb[j*32 +: 32] = $urandom;
            end
            if (k % 16 == 0) rb = ra;
            if (k % 16 == 1) ra = '1;
            rs = 1'(($urandom >> 3) & 1);
            rc = 1'($urandom & 1);
            wait_idle();
            issue(ra, rb, rs, rc, golden(ra, rb, rs, rc), 1);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_empty", TW'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
